moore_frame_tx: RTL and testbench
=================================

MOORE_FRAME_TX -- requirements
Module: moore_frame_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, inputClk cycles per transmitted bit (legal range 2..255).
REQ-002 Parameter PARITY_EN, default 1, 1 = even-parity bit inserted after data, 0 = no parity bit.
REQ-003 inputClk  input  1  sole clock, all state updates on rising edge.
REQ-004 inputR  input  1  reset, asynchronous, active-high.
REQ-005 inputData  input  8  frame payload, sampled on accept.
REQ-006 inputValid  input  1  payload offered this cycle.
REQ-007 outputReady  output  1  block can accept a payload this cycle.
REQ-008 outputSerial  output  1  serial line, idle high.
REQ-009 outputBusy  output  1  frame in progress.
REQ-010 outputDone  output  1  one-cycle pulse on the last cycle of the stop bit.

Function
REQ-011 Moore FSM, states IDLE, START, DATA, PARITY, STOP; all outputs decoded from registered state only, no input-to-output combinational path.
REQ-012 Accept = inputValid & outputReady at a rising edge; outputReady = 1 only in IDLE.
REQ-013 On accept: latch inputData into 8-bit shift register, compute even parity (XOR of 8 bits), go to START; first START cycle is the cycle after accept.
REQ-014 Line levels: IDLE 1, START 0, DATA current shift-register LSB (LSB first), PARITY latched parity bit, STOP 1.
REQ-015 Each of START, DATA bit, PARITY, STOP holds exactly CLKS_PER_BIT cycles, timed by a baud counter cleared on every bit boundary.
REQ-016 DATA lasts exactly 8 bit periods, tracked by a 3-bit index; shift register shifts right once per bit boundary.
REQ-017 Transitions: IDLE->START on accept; START->DATA; DATA->PARITY after bit 7 if PARITY_EN=1, else DATA->STOP; PARITY->STOP; STOP->IDLE.
REQ-018 Frame length = (10 + PARITY_EN) x CLKS_PER_BIT cycles from first START cycle to return to IDLE.
REQ-019 outputBusy = 1 in every state except IDLE.
REQ-020 outputDone = 1 only on the final STOP cycle; IDLE follows on the next edge.
REQ-021 inputValid and inputData ignored while not in IDLE; no buffering, no loss of the in-flight frame.
REQ-022 Back-to-back: inputValid held high yields a new accept on the first IDLE cycle, so minimum gap between frames is one idle-high cycle.
REQ-023 inputData changes after accept have no effect on the in-flight frame.

Reset
REQ-024 inputR high forces, immediately and independent of inputClk: state IDLE, baud counter 0, bit index 0, shift register 0, parity 0.
REQ-025 Outputs during and after reset: outputSerial 1, outputReady 1, outputBusy 0, outputDone 0.
REQ-026 Reset mid-frame aborts the frame; line returns high at once; no outputDone pulse for the aborted frame.
REQ-027 First accept possible on the first rising edge with inputR low.

Structure
REQ-028 Shared package holds state encoding constants (IDLE..STOP, 3-bit binary), LINE_IDLE = 1, DATA_BITS = 8.
REQ-029 State, baud counter, bit index, shift register, parity bit held in one sub-module tx_state_reg of asynchronous-reset rising-edge registers; next-state and output decode in the top module.

Verification
REQ-030 CLKS_PER_BIT=4, PARITY_EN=1, send 0xA5 -> line 0, then 1,0,1,0,0,1,0,1 (LSB first), parity 0, stop 1, each 4 cycles; outputDone pulses at cycle 44 after accept.
REQ-031 PARITY_EN=0, send 0x01 -> 40-cycle frame, bits 1,0,0,0,0,0,0,0, no parity slot; outputBusy high exactly 40 cycles.
REQ-032 inputValid held high with 0x3C then 0xC3 -> two frames separated by exactly one idle-high cycle; second carries 0xC3.
REQ-033 Assert inputR during DATA bit 3 -> outputSerial 1, outputBusy 0, outputReady 1 immediately; no outputDone; next frame 0xFF transmits correctly.
REQ-034 Change inputData and pulse inputValid during PARITY -> ignored; in-flight frame unchanged, no second frame started.
REQ-035 CLKS_PER_BIT=2, send 0x80 -> parity 1; every bit period exactly 2 cycles, frame 22 cycles.

Source files
------------

// File: rtl/moore_frame_tx_pkg.sv
// ============================================================================
// moore_frame_tx_pkg : shared state encoding and frame constants
// Revision: 1.0
// ============================================================================
`default_nettype none

package moore_frame_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam int   DATA_BITS = 8;

   function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tx_state_reg.sv
// ============================================================================
// tx_state_reg : asynchronous-reset holding registers for moore_frame_tx
// Revision: 1.0
// ============================================================================
`default_nettype none

module tx_state_reg
   import moore_frame_tx_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  tx_state_t            state_d,
   input  logic [7:0]           baud_d,
   input  logic [2:0]           idx_d,
   input  logic [DATA_BITS-1:0] shreg_d,
   input  logic                 parity_d,
   output tx_state_t            state_q,
   output logic [7:0]           baud_q,
   output logic [2:0]           idx_q,
   output logic [DATA_BITS-1:0] shreg_q,
   output logic                 parity_q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         baud_q   <= 8'd0;
         idx_q    <= 3'd0;
         shreg_q  <= '0;
         parity_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         idx_q    <= idx_d;
         shreg_q  <= shreg_d;
         parity_q <= parity_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/moore_frame_tx.sv
// ============================================================================
// moore_frame_tx : Moore-style serial frame transmitter, start/8 data/parity/stop
// Revision: 1.0
// ============================================================================
`default_nettype none

module moore_frame_tx
   import moore_frame_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 1
)
(
   input  logic       inputClk,
   input  logic       inputR,
   input  logic [7:0] inputData,
   input  logic       inputValid,
   output logic       outputReady,
   output logic       outputSerial,
   output logic       outputBusy,
   output logic       outputDone
);

   localparam logic [7:0] BAUD_LAST  = 8'(CLKS_PER_BIT - 1);
   localparam logic [2:0] LAST_BIT   = 3'(DATA_BITS - 1);
   localparam bit         HAS_PARITY = (PARITY_EN != 0);

   tx_state_t            state, state_nxt;
   logic [7:0]           baud, baud_nxt;
   logic [2:0]           idx, idx_nxt;
   logic [DATA_BITS-1:0] shreg, shreg_nxt;
   logic                 parity, parity_nxt;
   logic                 bit_end;

   tx_state_reg u_regs (
      .clk      (inputClk),
      .rst      (inputR),
      .state_d  (state_nxt),
      .baud_d   (baud_nxt),
      .idx_d    (idx_nxt),
      .shreg_d  (shreg_nxt),
      .parity_d (parity_nxt),
      .state_q  (state),
      .baud_q   (baud),
      .idx_q    (idx),
      .shreg_q  (shreg),
      .parity_q (parity)
   );

   assign bit_end = (baud == BAUD_LAST);

   always_comb begin
      state_nxt  = state;
      baud_nxt   = baud + 8'd1;
      idx_nxt    = idx;
      shreg_nxt  = shreg;
      parity_nxt = parity;
      case (state)
         ST_IDLE: begin
            baud_nxt = 8'd0;
            if (inputValid) begin
               state_nxt  = ST_START;
               idx_nxt    = 3'd0;
               shreg_nxt  = inputData;
               parity_nxt = even_parity(inputData);
            end
         end
         ST_START: begin
            if (bit_end) begin
               baud_nxt  = 8'd0;
               state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               baud_nxt  = 8'd0;
               shreg_nxt = shreg >> 1;
               idx_nxt   = idx + 3'd1;
               if (idx == LAST_BIT) begin
                  state_nxt = HAS_PARITY ? ST_PARITY : ST_STOP;
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               baud_nxt  = 8'd0;
               state_nxt = ST_STOP;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               baud_nxt  = 8'd0;
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            baud_nxt  = 8'd0;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Outputs depend only on registered state, never on inputValid/inputData.
   always_comb begin
      outputSerial = LINE_IDLE;
      case (state)
         ST_START:  outputSerial = 1'b0;
         ST_DATA:   outputSerial = shreg[0];
         ST_PARITY: outputSerial = parity;
         default:   outputSerial = LINE_IDLE;
      endcase
   end

   assign outputReady = (state == ST_IDLE);
   assign outputBusy  = (state != ST_IDLE);
   assign outputDone  = (state == ST_STOP) && bit_end;

endmodule

`default_nettype wire

// File: tb/tb_moore_frame_tx.sv
// ============================================================================
// tb_moore_frame_tx : randomized self-checking bench against a slot-based line model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_moore_frame_tx;

   logic       clk;
   logic       rst;
   logic [2:0] vld;
   logic [7:0] dat [3];
   logic [2:0] rdy, ser, bsy, dn;

   int total = 0;
   int bad   = 0;
   int busy_cnt;

   // Instance 0: 4 clk/bit with parity; 1: 4 clk/bit no parity; 2: 2 clk/bit with parity
   moore_frame_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) u_dut0 (
      .inputClk(clk), .inputR(rst), .inputData(dat[0]), .inputValid(vld[0]),
      .outputReady(rdy[0]), .outputSerial(ser[0]), .outputBusy(bsy[0]), .outputDone(dn[0]));
   moore_frame_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0)) u_dut1 (
      .inputClk(clk), .inputR(rst), .inputData(dat[1]), .inputValid(vld[1]),
      .outputReady(rdy[1]), .outputSerial(ser[1]), .outputBusy(bsy[1]), .outputDone(dn[1]));
   moore_frame_tx #(.CLKS_PER_BIT(2), .PARITY_EN(1)) u_dut2 (
      .inputClk(clk), .inputR(rst), .inputData(dat[2]), .inputValid(vld[2]),
      .outputReady(rdy[2]), .outputSerial(ser[2]), .outputBusy(bsy[2]), .outputDone(dn[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int cpb_of(input int sel);
      return (sel == 2) ? 2 : 4;
   endfunction

   function automatic int pe_of(input int sel);
      return (sel == 1) ? 0 : 1;
   endfunction

   // Expected line level k cycles after the accept edge (k=1 is the first start cycle).
   function automatic logic model_line(input logic [7:0] d, input int cpb, input int pe, input int k);
      int slot;
      if (k < 1) return 1'b1;
      slot = (k - 1) / cpb;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return d[slot-1];
      if (pe == 1 && slot == 9) return ^d;
      return 1'b1;
   endfunction

   task automatic check_idle(input int sel, input string tag);
      total++;
      if (ser[sel] !== 1'b1 || bsy[sel] !== 1'b0 || rdy[sel] !== 1'b1 || dn[sel] !== 1'b0) begin
         bad++;
         $display("FAIL idle_%s sel=%0d: got ser=%b busy=%b rdy=%b done=%b want ser=1 busy=0 rdy=1 done=0",
                  tag, sel, ser[sel], bsy[sel], rdy[sel], dn[sel]);
      end
   endtask

   // Checks every cycle of a frame already accepted; keep_valid holds the request high,
   // poke_k pulses a request with random data on that one cycle.
   task automatic check_frame(input int sel, input logic [7:0] d, input bit keep_valid, input int poke_k);
      int cpb, pe, len;
      logic exp_ser;
      cpb = cpb_of(sel);
      pe  = pe_of(sel);
      len = (10 + pe) * cpb;
      busy_cnt = 0;
      for (int k = 1; k <= len; k++) begin
         @(negedge clk);
         vld[sel] = keep_valid || (k == poke_k);
         dat[sel] = 8'($urandom);
         exp_ser  = model_line(d, cpb, pe, k);
         if (bsy[sel] === 1'b1) busy_cnt++;
         total++;
         if (ser[sel] !== exp_ser || bsy[sel] !== 1'b1 || rdy[sel] !== 1'b0 || dn[sel] !== (k == len)) begin
            bad++;
            $display("FAIL frame sel=%0d d=%h k=%0d: got ser=%b busy=%b rdy=%b done=%b want ser=%b busy=1 rdy=0 done=%b",
                     sel, d, k, ser[sel], bsy[sel], rdy[sel], dn[sel], exp_ser, (k == len));
         end
      end
   endtask

   task automatic send(input int sel, input logic [7:0] d, input bit keep_valid, input int poke_k);
      @(negedge clk);
      check_idle(sel, "pre_accept");
      vld[sel] = 1'b1;
      dat[sel] = d;
      check_frame(sel, d, keep_valid, poke_k);
   endtask

   task automatic check_quiet(input int sel, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         vld[sel] = 1'b0;
         check_idle(sel, "quiet");
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 3; s++) check_idle(s, "reset");
      rst = 1'b0;
      @(negedge clk);
      for (int s = 0; s < 3; s++) check_idle(s, "after_reset");
   endtask

   task automatic test_a5;
      send(0, 8'hA5, 1'b0, 0);
      check_quiet(0, 2);
   endtask

   task automatic test_no_parity;
      send(1, 8'h01, 1'b0, 0);
      total++;
      if (busy_cnt != 40) begin
         bad++;
         $display("FAIL busy_len: got %0d want 40", busy_cnt);
      end
      check_quiet(1, 2);
   endtask

   task automatic test_back_to_back;
      send(0, 8'h3C, 1'b1, 0);
      send(0, 8'hC3, 1'b0, 0);
      check_quiet(0, 2);
   endtask

   task automatic test_reset_mid;
      logic [7:0] d;
      d = 8'($urandom);
      @(negedge clk);
      vld[0] = 1'b1;
      dat[0] = d;
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         vld[0] = 1'b0;
      end
      total++;
      if (ser[0] !== d[3] || bsy[0] !== 1'b1) begin
         bad++;
         $display("FAIL mid_bit3: got ser=%b busy=%b want ser=%b busy=1", ser[0], bsy[0], d[3]);
      end
      #2 rst = 1'b1;
      #1 check_idle(0, "async_reset");
      @(posedge clk);
      #1 check_idle(0, "in_reset");
      @(negedge clk);
      rst = 1'b0;
      check_quiet(0, 3);
      send(0, 8'hFF, 1'b0, 0);
      check_quiet(0, 1);
   endtask

   task automatic test_ignore_parity;
      logic [7:0] d;
      d = 8'($urandom);
      send(0, d, 1'b0, 38);
      check_quiet(0, 6);
   endtask

   task automatic test_cpb2;
      send(2, 8'h80, 1'b0, 0);
      check_quiet(2, 1);
   endtask

   task automatic test_random;
      for (int i = 0; i < 6; i++) begin
         int sel;
         sel = i % 3;
         send(sel, 8'($urandom), 1'b0, 0);
         check_quiet(sel, 1);
      end
   endtask

   initial begin
      rst = 1'b1;
      vld = 3'b000;
      for (int s = 0; s < 3; s++) dat[s] = 8'h00;
      test_reset;
      test_a5;
      test_no_parity;
      test_back_to_back;
      test_reset_mid;
      test_ignore_parity;
      test_cpb2;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
